// File: rtl/seq_mov_pkg.sv
// Shared encodings for the sequential move/shift unit: operation modes,
// FSM state encoding and a helper that says which modes consume the count.
// Rotate support is controlled by the SEQ_MOV_ROTATE_EN macro.
package seq_mov_pkg;

    localparam logic [2:0] MODE_MOV = 3'b000;
    localparam logic [2:0] MODE_NOT = 3'b001;
    localparam logic [2:0] MODE_SHL = 3'b010;
    localparam logic [2:0] MODE_SHR = 3'b011;
    localparam logic [2:0] MODE_ASR = 3'b100;
    localparam logic [2:0] MODE_ROL = 3'b101;
    localparam logic [2:0] MODE_ROR = 3'b110;
    localparam logic [2:0] MODE_RSV = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when the mode walks the step counter; every other mode finishes
    // with a zero count and returns the latched operand as-is.
    function automatic logic mode_steps(input logic [2:0] m);
        logic r;
        r = 1'b0;
        case (m)
            MODE_SHL, MODE_SHR, MODE_ASR: r = 1'b1;
`ifdef SEQ_MOV_ROTATE_EN
            MODE_ROL, MODE_ROR:           r = 1'b1;
`endif
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit step of the latched mode applied to the work
// register. Rotates exist only when SEQ_MOV_ROTATE_EN is defined; otherwise
// those modes fall through to a pass-through like MOV.
module shift_step
    import seq_mov_pkg::*;
#(
    parameter int Nsize = 8
) (
    input  logic [Nsize-1:0] work,
    input  logic [2:0]       mode,
    output logic [Nsize-1:0] next_work
);

    // One-bit move of work according to mode; unstepped modes pass through.
    always_comb begin
        next_work = work;
        case (mode)
            MODE_SHL: next_work = {work[Nsize-2:0], 1'b0};
            MODE_SHR: next_work = {1'b0, work[Nsize-1:1]};
            MODE_ASR: next_work = {work[Nsize-1], work[Nsize-1:1]};
`ifdef SEQ_MOV_ROTATE_EN
            MODE_ROL: next_work = {work[Nsize-2:0], work[Nsize-1]};
            MODE_ROR: next_work = {work[0], work[Nsize-1:1]};
`endif
            default:  next_work = work;
        endcase
    end

endmodule

// File: rtl/seq_mov_shift.sv
// Sequential move/shift unit: latches an operand on start, steps it one bit
// per cycle for amt cycles, then publishes it in result with a one-cycle done.
// Handshake: start is sampled only while idle (busy=0); while busy=1 start is
// ignored; done is high for exactly one cycle and result is valid from that
// cycle until the next done. Optional rotate modes: SEQ_MOV_ROTATE_EN.
module seq_mov_shift
    import seq_mov_pkg::*;
#(
    parameter  int Nsize = 8,
    localparam int Asize = $clog2(Nsize)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [Nsize-1:0] a,
    input  logic [Asize-1:0] amt,
    output logic [Nsize-1:0] result,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    state_t           state_q, state_d;
    logic [Nsize-1:0] work_q;
    logic [Nsize-1:0] work_step;
    logic [Asize-1:0] cnt_q;
    logic [2:0]       mode_q;
    logic [Nsize-1:0] result_q;

    shift_step #(.Nsize(Nsize)) u_step (
        .work      (work_q),
        .mode      (mode_q),
        .next_work (work_step)
    );

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE when count is spent,
    // DONE -> IDLE unconditionally.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register plus datapath: latch on accept, step while counting,
    // publish result on the way into DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            mode_q   <= MODE_MOV;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        work_q <= (mode == MODE_NOT) ? ~a : a;
                        mode_q <= mode;
                        cnt_q  <= mode_steps(mode) ? amt : '0;
                    end
                end
                ST_RUN: begin
                    if (cnt_q != '0) begin
                        work_q <= work_step;
                        cnt_q  <= cnt_q - Asize'(1);
                    end else begin
                        result_q <= work_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = result_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_mov_shift.sv
// Bench for seq_mov_shift (Nsize=8): directed cases plus random operations,
// a scoreboard of expected result/done-cycle pairs and a monitor that checks
// every done pulse and that result holds between pulses.
module tb_seq_mov_shift;

    localparam int N = 8;
    localparam int A = $clog2(N);

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   mode;
    logic [N-1:0] a;
    logic [A-1:0] amt;
    logic [N-1:0] result;
    logic         busy;
    logic         done;
    logic [1:0]   state_dbg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit in_reset = 1'b1;
    logic [N-1:0] last_res = '0;

    logic [N-1:0] exp_q[$];
    int           exp_cyc_q[$];

    seq_mov_shift #(.Nsize(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .a         (a),
        .amt       (amt),
        .result    (result),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // reference model: whole-operand arithmetic over the effective count
    function automatic bit rotate_on();
`ifdef SEQ_MOV_ROTATE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int eff_amt(input logic [2:0] m, input int n);
        if (m == 3'b010 || m == 3'b011 || m == 3'b100) return n;
        if ((m == 3'b101 || m == 3'b110) && rotate_on()) return n;
        return 0;
    endfunction

    function automatic logic [N-1:0] model(input logic [2:0] m, input logic [N-1:0] v, input int n);
        logic signed [N-1:0] sv;
        logic [2*N-1:0] dbl;
        int k;
        k = eff_amt(m, n);
        sv = v;
        dbl = {v, v};
        case (m)
            3'b001:  return ~v;
            3'b010:  return v << k;
            3'b011:  return v >> k;
            3'b100:  return sv >>> k;
            3'b101:  begin dbl = dbl << k; return rotate_on() ? dbl[2*N-1:N] : v; end
            3'b110:  begin dbl = dbl >> k; return rotate_on() ? dbl[N-1:0] : v; end
            default: return v;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // monitor: pops one expectation per done, else result must hold
    always @(negedge clk) begin
        if (in_reset) begin
            last_res = result;
        end else begin
            if (done) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: result=%0h at cycle %0d", result, cyc);
                end else begin
                    logic [N-1:0] er;
                    int ec;
                    er = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    if (result != er) begin
                        bad++;
                        $display("FAIL result: got %0h expected %0h (cycle %0d)", result, er, cyc);
                    end
                    check("done_cycle", cyc, ec);
                end
            end else begin
                check("result_hold", result, last_res);
            end
            last_res = result;
        end
    end

    // driver: wait for idle (bounded), issue one op, scramble inputs after
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy stuck at cycle %0d", cyc);
        end
    endtask

    task automatic do_op(input logic [2:0] m, input logic [N-1:0] av, input int n, input bit extra);
        int lim;
        wait_idle();
        start = 1'b1;
        mode  = m;
        a     = av;
        amt   = A'(n);
        @(posedge clk);
        #1;
        exp_q.push_back(model(m, av, n));
        exp_cyc_q.push_back(cyc + eff_amt(m, n) + 1);
        start = 1'b0;
        mode  = 3'($urandom_range(0, 7));
        a     = N'($urandom_range(0, 255));
        amt   = A'($urandom_range(0, N - 1));
        if (extra) begin
            lim = 0;
            while (lim < 12) begin
                @(negedge clk);
                if (!busy) begin
                    start = 1'b0;
                    break;
                end
                start = 1'($urandom_range(0, 1));
                a     = N'($urandom_range(0, 255));
                lim++;
            end
            start = 1'b0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_result"}, result, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = '0;
        a     = '0;
        amt   = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;

        // directed cases
        do_op(3'b000, 8'hA5, 5, 0);
        do_op(3'b001, 8'h0F, 3, 0);
        do_op(3'b010, 8'h81, 3, 0);
        do_op(3'b100, 8'h90, 2, 0);
        do_op(3'b011, 8'h90, 2, 0);
        do_op(3'b110, 8'h01, 1, 0);
        do_op(3'b101, 8'h80, 7, 0);
        do_op(3'b010, 8'h01, 7, 0);
        do_op(3'b100, 8'h80, 7, 0);
        do_op(3'b011, 8'h80, 7, 0);
        do_op(3'b111, 8'h3C, 6, 0);
        do_op(3'b100, 8'hC3, 0, 0);
        do_op(3'b010, 8'h5A, 4, 1);
        do_op(3'b000, 8'h77, 0, 1);

        // reset in the middle of a long operation: no done, result cleared
        do_op(3'b010, 8'hFF, 7, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        in_reset = 1'b1;
        exp_q.delete();
        exp_cyc_q.delete();
        @(negedge clk);
        check_reset_state("midrun_reset");
        rst_n = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;
        do_op(3'b011, 8'hF0, 4, 0);

        // random operations
        for (int i = 0; i < 60; i++) begin
            do_op(3'($urandom_range(0, 7)), N'($urandom_range(0, 255)),
                  $urandom_range(0, N - 1), 1'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_mov_shift.md
SEQ_MOV_SHIFT -- requirements
Module: seq_mov_shift

Interface
- REQ-001: The module SHALL have parameter Nsize, default 8, meaning datapath width in bits; Nsize SHALL be a power of two and at least 2.
- REQ-002: The module SHALL have derived constant Asize = clog2(Nsize), meaning shift-amount width in bits.
- REQ-003: clk  input  1  single clock; all state SHALL update on the rising edge.
- REQ-004: rst_n  input  1  synchronous, active-low reset.
- REQ-005: start  input  1  request strobe; it SHALL be sampled only in IDLE.
- REQ-006: mode  input  3  operation select.
- REQ-007: a  input  Nsize  operand.
- REQ-008: amt  input  Asize  shift/rotate count, 0..Nsize-1.
- REQ-009: result  output  Nsize  registered result.
- REQ-010: busy  output  1  high in RUN and DONE.
- REQ-011: done  output  1  one-cycle pulse marking result valid.

Function
- REQ-012: Mode encoding SHALL be: 000 MOV, 001 NOT, 010 SHL (zero fill), 011 SHR (zero fill), 100 ASR (sign fill), 101 ROL, 110 ROR, 111 reserved; reserved SHALL execute as MOV.
- REQ-013: The FSM SHALL have exactly three states, IDLE, RUN and DONE.
- REQ-014: In IDLE with start=1, the module SHALL latch a (inverted for NOT) into a work register, latch mode, load a step counter with amt (forced to 0 for MOV, NOT and reserved) and go to RUN.
- REQ-015: In RUN with counter != 0, the module SHALL apply one 1-bit step of the latched mode to work and decrement the counter.
- REQ-016: In RUN with counter == 0, the module SHALL copy work to result and go to DONE.
- REQ-017: DONE SHALL assert done for exactly one cycle, then return unconditionally to IDLE.
- REQ-018: done SHALL rise amt+1 clock edges after the edge that sampled start (1 edge for MOV, NOT, or amt=0).
- REQ-019: start SHALL be ignored while busy=1; no queuing, and no change to the operation in flight.
- REQ-020: Input changes after the start edge SHALL NOT affect the operation in flight.
- REQ-021: result SHALL change only on entry to DONE and SHALL otherwise hold its last value indefinitely.
- REQ-022: Shifts SHALL be exact at the extremes: amt = Nsize-1 with SHL leaves only bit 0 moved to the MSB; ASR fills every vacated bit with the latched MSB.
- REQ-023: Any mode with amt=0 SHALL return the latched operand unchanged.

Reset
- REQ-024: When rst_n=0 at a clock edge, the module SHALL set state=IDLE, result=0, busy=0, done=0, counter=0 and work=0.
- REQ-025: Reset SHALL take priority over start and SHALL abort any RUN or DONE operation with no done pulse.
- REQ-026: The first start after reset release SHALL be accepted normally.

Configuration
- REQ-027: The macro SEQ_MOV_ROTATE_EN SHALL control rotate support.
- REQ-028: With SEQ_MOV_ROTATE_EN defined, modes 101 and 110 SHALL rotate by one bit per step.
- REQ-029: Without SEQ_MOV_ROTATE_EN, modes 101 and 110 SHALL execute as MOV (counter forced 0) and no rotate logic SHALL be synthesised.

Structure
- REQ-030: Package seq_mov_pkg SHALL hold the mode encodings and the FSM state encoding.
- REQ-031: Sub-module shift_step SHALL be a combinational single-bit step (inputs: work, mode; output: next work), instantiated once.

Verification (Nsize=8)
- REQ-032: MOV: a=8'hA5 -> result=8'hA5; done 1 edge after start.
- REQ-033: NOT a=8'h0F -> result=8'hF0; SHL a=8'h81, amt=3 -> result=8'h08, done 4 edges after start.
- REQ-034: ASR a=8'h90, amt=2 -> result=8'hE4; SHR a=8'h90, amt=2 -> result=8'h24.
- REQ-035: ROR a=8'h01, amt=1 -> result=8'h80 with SEQ_MOV_ROTATE_EN, 8'h01 without; ROL a=8'h80, amt=7 -> result=8'h40 with the macro.
- REQ-036: Extra start pulses during busy -> exactly one done and the original result.
- REQ-037: rst_n=0 mid-RUN -> next cycle IDLE, result=8'h00, no done.
